// File: rtl/gp_control_regs_if.sv
// AXI4-Lite bus bundle (32-bit data) shared by the GP_CONTROL master and the
// PL register bank; protection signals are not carried because nothing uses them.
interface axi4_lite_if #(
   parameter int ADDR_W = 12
) ();
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport m (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport s (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/gp_control_regs.sv
// PL control/status register bank behind the PS GP_CONTROL AXI4-Lite port:
// ID, scratch, control bits, HP0 address offset, live status and a cycle counter.
module gp_control_regs #(
   parameter int          ADDR_W     = 12,
   parameter int          HP0_ADDR_W = 32,
   parameter int          STATUS_W   = 8,
   parameter logic [31:0] ID_VALUE   = 32'hFB00_0001
) (
   input  logic                  peripheral_clock,
   input  logic                  peripheral_reset,
   axi4_lite_if.s                ctrl,
   input  logic [STATUS_W-1:0]   status_i,
   output logic                  enable_o,
   output logic                  soft_reset_o,
   output logic [HP0_ADDR_W-1:0] hp0_offset_o
);

   localparam logic [31:0] IDX_ID      = 32'd0;
   localparam logic [31:0] IDX_SCRATCH = 32'd1;
   localparam logic [31:0] IDX_CTRL    = 32'd2;
   localparam logic [31:0] IDX_HP0     = 32'd3;
   localparam logic [31:0] IDX_STATUS  = 32'd4;
   localparam logic [31:0] IDX_CYCLE   = 32'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wState_t;
   typedef enum logic       {R_IDLE, R_RESP} rState_t;

   wState_t r_wState, w_wStateNext;
   rState_t r_rState, w_rStateNext;

   logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
   logic              w_awreadyNext, w_wreadyNext, w_bvalidNext;
   logic              w_arreadyNext, w_rvalidNext;
   logic [1:0]        r_bresp, r_rresp;
   logic [31:0]       r_rdata;

   logic [ADDR_W-1:0] r_awAddr;
   logic [31:0]       r_wData;
   logic [3:0]        r_wStrb;

   logic [31:0]           r_scratch;
   logic                  r_enable;
   logic                  r_softReset;
   logic [HP0_ADDR_W-1:0] r_hp0Offset;
   logic [31:0]           r_cycleCnt;

   logic              w_awHs, w_wHs, w_bHs, w_arHs, w_rHs;
   logic              w_commit;
   logic [ADDR_W-1:0] w_cmtAddr;
   logic [31:0]       w_cmtData;
   logic [3:0]        w_cmtStrb;
   logic [31:0]       w_wrIdx, w_rdIdx;
   logic              w_wrValid;
   logic [31:0]       w_rdData;
   logic              w_rdErr;
   logic              w_unused;

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = strb[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
      end
      return res;
   endfunction

   assign w_awHs = ctrl.awvalid & r_awready;
   assign w_wHs  = ctrl.wvalid  & r_wready;
   assign w_bHs  = r_bvalid     & ctrl.bready;
   assign w_arHs = ctrl.arvalid & r_arready;
   assign w_rHs  = r_rvalid     & ctrl.rready;

   // Whichever half of the write arrived first was latched; the other half is live on the bus.
   assign w_cmtAddr = (r_wState == W_ADDR) ? r_awAddr : ctrl.awaddr;
   assign w_cmtData = (r_wState == W_DATA) ? r_wData  : ctrl.wdata;
   assign w_cmtStrb = (r_wState == W_DATA) ? r_wStrb  : ctrl.wstrb;
   assign w_commit  = (w_wStateNext == W_RESP) && (r_wState != W_RESP);

   assign w_wrIdx   = 32'(w_cmtAddr[ADDR_W-1:2]);
   assign w_rdIdx   = 32'(ctrl.araddr[ADDR_W-1:2]);
   assign w_wrValid = (w_wrIdx <= IDX_CYCLE);
   assign w_unused  = ^{w_cmtAddr[1:0], ctrl.araddr[1:0]};

   always_comb begin
      w_wStateNext = r_wState;
      case (r_wState)
         W_IDLE: begin
            if (w_awHs && w_wHs) w_wStateNext = W_RESP;
            else if (w_awHs)     w_wStateNext = W_ADDR;
            else if (w_wHs)      w_wStateNext = W_DATA;
         end
         W_ADDR:  if (w_wHs)  w_wStateNext = W_RESP;
         W_DATA:  if (w_awHs) w_wStateNext = W_RESP;
         W_RESP:  if (w_bHs)  w_wStateNext = W_IDLE;
         default: w_wStateNext = W_IDLE;
      endcase
   end

   // Handshake outputs are registered, so they are derived from the next state.
   always_comb begin
      w_awreadyNext = (w_wStateNext == W_IDLE) || (w_wStateNext == W_DATA);
      w_wreadyNext  = (w_wStateNext == W_IDLE) || (w_wStateNext == W_ADDR);
      w_bvalidNext  = (w_wStateNext == W_RESP);
   end

   always_ff @(posedge peripheral_clock) begin
      if (peripheral_reset) begin
         r_wState  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_awAddr  <= '0;
         r_wData   <= '0;
         r_wStrb   <= '0;
      end else begin
         r_wState  <= w_wStateNext;
         r_awready <= w_awreadyNext;
         r_wready  <= w_wreadyNext;
         r_bvalid  <= w_bvalidNext;
         if (w_awHs) r_awAddr <= ctrl.awaddr;
         if (w_wHs) begin
            r_wData <= ctrl.wdata;
            r_wStrb <= ctrl.wstrb;
         end
         if (w_commit) r_bresp <= w_wrValid ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge peripheral_clock) begin
      if (peripheral_reset) begin
         r_scratch   <= '0;
         r_enable    <= 1'b0;
         r_softReset <= 1'b0;
         r_hp0Offset <= '0;
         r_cycleCnt  <= '0;
      end else begin
         r_softReset <= 1'b0;
         r_cycleCnt  <= r_cycleCnt + 32'd1;
         // A clear of the counter overrides this cycle's increment.
         if (w_commit) begin
            case (w_wrIdx)
               IDX_SCRATCH: r_scratch <= mergeBytes(r_scratch, w_cmtData, w_cmtStrb);
               IDX_CTRL: begin
                  if (w_cmtStrb[0]) begin
                     r_enable    <= w_cmtData[0];
                     r_softReset <= w_cmtData[1];
                  end
               end
               IDX_HP0: r_hp0Offset <= HP0_ADDR_W'(mergeBytes(32'(r_hp0Offset), w_cmtData, w_cmtStrb));
               IDX_CYCLE: begin
                  if (|w_cmtStrb) r_cycleCnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_rdData = 32'd0;
      w_rdErr  = 1'b0;
      case (w_rdIdx)
         IDX_ID:      w_rdData = ID_VALUE;
         IDX_SCRATCH: w_rdData = r_scratch;
         IDX_CTRL:    w_rdData = {31'd0, r_enable};
         IDX_HP0:     w_rdData = 32'(r_hp0Offset);
         IDX_STATUS:  w_rdData = 32'(status_i);
         IDX_CYCLE:   w_rdData = r_cycleCnt;
         default:     w_rdErr  = 1'b1;
      endcase
   end

   always_comb begin
      w_rStateNext = r_rState;
      case (r_rState)
         R_IDLE:  if (w_arHs) w_rStateNext = R_RESP;
         R_RESP:  if (w_rHs)  w_rStateNext = R_IDLE;
         default: w_rStateNext = R_IDLE;
      endcase
   end

   always_comb begin
      w_arreadyNext = (w_rStateNext == R_IDLE);
      w_rvalidNext  = (w_rStateNext == R_RESP);
   end

   always_ff @(posedge peripheral_clock) begin
      if (peripheral_reset) begin
         r_rState  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_rState  <= w_rStateNext;
         r_arready <= w_arreadyNext;
         r_rvalid  <= w_rvalidNext;
         if (w_arHs) begin
            r_rdata <= w_rdData;
            r_rresp <= w_rdErr ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign ctrl.awready = r_awready;
   assign ctrl.wready  = r_wready;
   assign ctrl.bvalid  = r_bvalid;
   assign ctrl.bresp   = r_bresp;
   assign ctrl.arready = r_arready;
   assign ctrl.rvalid  = r_rvalid;
   assign ctrl.rdata   = r_rdata;
   assign ctrl.rresp   = r_rresp;

   assign enable_o     = r_enable;
   assign soft_reset_o = r_softReset;
   assign hp0_offset_o = r_hp0Offset;

endmodule

// File: tb/tb_gp_control_regs.sv
// Directed bench for gp_control_regs: register map, handshake ordering,
// error responses, counter clear/wrap, back-pressure and mid-write reset.
module tb_gp_control_regs;

   logic        clk;
   logic        reset;
   logic [7:0]  statusIn;
   logic        enableOut;
   logic        softResetOut;
   logic [31:0] hp0Out;

   int testCount = 0;
   int failCount = 0;

   logic        softAtCommit;
   logic        softAfter;
   logic [31:0] rdVal;
   logic [1:0]  rdResp;

   axi4_lite_if #(.ADDR_W(12)) bus ();

   gp_control_regs #(
      .ADDR_W(12), .HP0_ADDR_W(32), .STATUS_W(8), .ID_VALUE(32'hFB00_0001)
   ) dut (
      .peripheral_clock (clk),
      .peripheral_reset (reset),
      .ctrl             (bus),
      .status_i         (statusIn),
      .enable_o         (enableOut),
      .soft_reset_o     (softResetOut),
      .hp0_offset_o     (hp0Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic sendAw(input string tag);
      int n = 0;
      bus.awvalid = 1'b1;
      while (!bus.awready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) checkOutput(tag, 32'(bus.awready), 32'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
   endtask

   task automatic sendW(input string tag);
      int n = 0;
      bus.wvalid = 1'b1;
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) checkOutput(tag, 32'(bus.wready), 32'd1);
      @(negedge clk);
      bus.wvalid = 1'b0;
   endtask

   // mode 0: AW and W together; 1: W three cycles before AW; 2: AW three cycles before W
   task automatic axiWriteStart(input logic [11:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int mode);
      int n = 0;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      if (mode == 0) begin
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
         while (!(bus.awready && bus.wready) && n < 50) begin @(negedge clk); n++; end
         if (n >= 50) checkOutput("wr_ready_timeout", 32'(bus.awready & bus.wready), 32'd1);
         @(negedge clk);
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
      end else if (mode == 1) begin
         sendW("wr_wready_timeout");
         repeat (2) @(negedge clk);
         checkOutput("wr_w_first_no_bvalid", 32'(bus.bvalid), 32'd0);
         sendAw("wr_awready_timeout");
      end else begin
         sendAw("wr_awready_timeout");
         repeat (2) @(negedge clk);
         checkOutput("wr_aw_first_no_bvalid", 32'(bus.bvalid), 32'd0);
         sendW("wr_wready_timeout");
      end
      checkOutput("wr_bvalid_after_hs", 32'(bus.bvalid), 32'd1);
      softAtCommit = softResetOut;
   endtask

   task automatic axiWriteFinish(output logic [1:0] resp);
      int n = 0;
      while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) checkOutput("wr_bvalid_timeout", 32'(bus.bvalid), 32'd1);
      resp = bus.bresp;
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      softAfter = softResetOut;
   endtask

   task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode, output logic [1:0] resp);
      axiWriteStart(addr, data, strb, mode);
      axiWriteFinish(resp);
   endtask

   task automatic axiReadStart(input logic [11:0] addr);
      int n = 0;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      while (!bus.arready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) checkOutput("rd_arready_timeout", 32'(bus.arready), 32'd1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) checkOutput("rd_rvalid_timeout", 32'(bus.rvalid), 32'd1);
      rdVal  = bus.rdata;
      rdResp = bus.rresp;
   endtask

   task automatic axiReadFinish();
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
   endtask

   task automatic axiRead(input logic [11:0] addr);
      axiReadStart(addr);
      axiReadFinish();
   endtask

   task automatic applyStimulus();
      logic [1:0]  wResp;
      logic [31:0] firstCnt;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_awready", 32'(bus.awready), 32'd0);
      checkOutput("rst_wready", 32'(bus.wready), 32'd0);
      checkOutput("rst_arready", 32'(bus.arready), 32'd0);
      checkOutput("rst_bvalid", 32'(bus.bvalid), 32'd0);
      checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
      checkOutput("rst_enable", 32'(enableOut), 32'd0);
      checkOutput("rst_soft", 32'(softResetOut), 32'd0);
      checkOutput("rst_hp0", hp0Out, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_awready", 32'(bus.awready), 32'd1);
      checkOutput("post_rst_wready", 32'(bus.wready), 32'd1);
      checkOutput("post_rst_arready", 32'(bus.arready), 32'd1);

      axiRead(12'h000);
      checkOutput("id_rdata", rdVal, 32'hFB00_0001);
      checkOutput("id_rresp", 32'(rdResp), 32'd0);

      // SCRATCH through all three handshake orderings
      for (int m = 0; m < 3; m++) begin
         axiWrite(12'h004, 32'hDEAD_BEEF, 4'hF, m, wResp);
         checkOutput("scratch_bresp", 32'(wResp), 32'd0);
         axiRead(12'h004);
         checkOutput("scratch_readback", rdVal, 32'hDEAD_BEEF);
      end
      axiWrite(12'h004, 32'h0000_1234, 4'b0001, 0, wResp);
      axiRead(12'h004);
      checkOutput("scratch_byte0", rdVal, 32'hDEAD_BE34);
      axiWrite(12'h004, 32'hFFFF_FFFF, 4'b0000, 0, wResp);
      checkOutput("strb0_bresp", 32'(wResp), 32'd0);
      axiRead(12'h004);
      checkOutput("strb0_nochange", rdVal, 32'hDEAD_BE34);

      axiWrite(12'h00C, 32'h1000_0000, 4'hF, 0, wResp);
      checkOutput("hp0_out", hp0Out, 32'h1000_0000);
      checkOutput("soft_idle", 32'(softAtCommit), 32'd0);
      axiWrite(12'h008, 32'h0000_0003, 4'hF, 0, wResp);
      checkOutput("soft_pulse_high", 32'(softAtCommit), 32'd1);
      checkOutput("soft_pulse_gone", 32'(softAfter), 32'd0);
      checkOutput("enable_out", 32'(enableOut), 32'd1);
      axiRead(12'h008);
      checkOutput("ctrl_readback", rdVal, 32'h0000_0001);
      axiRead(12'h00C);
      checkOutput("hp0_readback", rdVal, 32'h1000_0000);

      statusIn = 8'hA5;
      axiRead(12'h010);
      checkOutput("status_read", rdVal, 32'h0000_00A5);

      // Unmapped offset
      axiRead(12'h020);
      checkOutput("bad_rdata", rdVal, 32'd0);
      checkOutput("bad_rresp", 32'(rdResp), 32'd2);
      axiWrite(12'h020, 32'hFFFF_FFFF, 4'hF, 0, wResp);
      checkOutput("bad_bresp", 32'(wResp), 32'd2);
      axiRead(12'h004);
      checkOutput("bad_wr_scratch", rdVal, 32'hDEAD_BE34);
      checkOutput("bad_wr_hp0", hp0Out, 32'h1000_0000);
      checkOutput("bad_wr_enable", 32'(enableOut), 32'd1);

      // Counter clear: cleared on commit edge, read two edges later
      axiWrite(12'h014, 32'd0, 4'b0001, 0, wResp);
      axiRead(12'h014);
      firstCnt = rdVal;
      checkOutput("cnt_after_clear", firstCnt, 32'd1);
      axiRead(12'h014);
      checkOutput("cnt_monotonic", 32'(rdVal > firstCnt), 32'd1);

      @(negedge clk);
      force dut.r_cycleCnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_cycleCnt;
      @(negedge clk);
      axiRead(12'h014);
      checkOutput("cnt_wrap", rdVal, 32'd0);

      // Back-pressure on B with a competing AW
      axiWriteStart(12'h004, 32'hA5A5_0F0F, 4'hF, 0);
      bus.awaddr  = 12'h008;
      bus.awvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hold_bvalid", 32'(bus.bvalid), 32'd1);
         checkOutput("hold_bresp", 32'(bus.bresp), 32'd0);
         checkOutput("hold_awready", 32'(bus.awready), 32'd0);
      end
      bus.awvalid = 1'b0;
      axiWriteFinish(wResp);
      checkOutput("hold_wr_bresp", 32'(wResp), 32'd0);

      // Back-pressure on R with a competing AR
      axiReadStart(12'h004);
      bus.araddr  = 12'h020;
      bus.arvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("hold_rvalid", 32'(bus.rvalid), 32'd1);
         checkOutput("hold_rdata", bus.rdata, 32'hA5A5_0F0F);
         checkOutput("hold_rresp", 32'(bus.rresp), 32'd0);
         checkOutput("hold_arready", 32'(bus.arready), 32'd0);
      end
      bus.arvalid = 1'b0;
      axiReadFinish();

      // Reset with a write response pending
      axiWriteStart(12'h004, 32'h1234_5678, 4'hF, 0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_bvalid", 32'(bus.bvalid), 32'd0);
      checkOutput("midrst_awready", 32'(bus.awready), 32'd0);
      checkOutput("midrst_enable", 32'(enableOut), 32'd0);
      checkOutput("midrst_hp0", hp0Out, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midrst_wready_back", 32'(bus.wready), 32'd1);
      axiRead(12'h004);
      checkOutput("midrst_scratch", rdVal, 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      statusIn    = 8'h00;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      softAtCommit = 1'b0;
      softAfter    = 1'b0;
      rdVal        = '0;
      rdResp       = '0;
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
